// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep controller.
package gate_sweep_pkg;

    // Sweep sequencer states; the encoding is fixed so debug traces stay readable.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Expected truth tables for common 2-input gates; bit k = output for input value k.
    localparam logic [3:0] EXPECT_OR   = 4'b1110;
    localparam logic [3:0] EXPECT_AND  = 4'b1000;
    localparam logic [3:0] EXPECT_NAND = 4'b0111;
    localparam logic [3:0] EXPECT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Control/result bundle between a test harness (master) and the sweep controller (slave).
interface gate_sweep_ctrl_if #(
    parameter int N_IN = 2
);
    logic                    start;
    logic                    abort;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [N_IN:0]           err_count;
    logic [N_IN-1:0]         first_err_idx;
    logic [(1<<N_IN)-1:0]    captured;

    modport master (
        output start, abort,
        input  busy, done, pass, err_count, first_err_idx, captured
    );

    modport slave (
        input  start, abort,
        output busy, done, pass, err_count, first_err_idx, captured
    );
endinterface

// File: rtl/gate_sweep_ctrl_settle_counter.sv
// Down-counter that times how long each vector is held before it is sampled.
module settle_counter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Reload on a new vector, otherwise count down while settling, never below zero.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CW'(SETTLE_CYCLES);
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Last settling cycle: the FSM moves to SAMPLE on the next edge.
    assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps a combinational gate through every input value, captures its outputs
// and scores them against an expected truth table.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                    N_IN          = 2,
    parameter int                    SETTLE_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0]  EXPECT        = EXPECT_OR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gate_sweep_ctrl_if.slave         ctl_if,
    output logic [N_IN-1:0]          x_out_o,
    input  logic                     s_in_i
);
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    state_e                  state_q;
    logic [N_IN-1:0]         idx_q;
    logic [N_IN-1:0]         x_out_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic [N_IN:0]           err_q;
    logic [N_IN-1:0]         first_q;
    logic [(1<<N_IN)-1:0]    captured_q;

    logic                    accept;
    logic                    mismatch;
    logic [N_IN:0]           err_d;
    logic                    cnt_load;
    logic                    cnt_dec;
    logic                    cnt_expire;

    // Decode handshake and scoreboard terms from the current state.
    assign accept   = (state_q == IDLE) && ctl_if.start && !ctl_if.abort;
    assign mismatch = (s_in_i != EXPECT[idx_q]);
    assign err_d    = err_q + (N_IN+1)'(mismatch);
    assign cnt_load = accept ||
                      ((state_q == SAMPLE) && !ctl_if.abort && (idx_q != LAST_IDX));
    assign cnt_dec  = (state_q == SETTLE);

    settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (cnt_load),
        .dec_i    (cnt_dec),
        .expire_o (cnt_expire)
    );

    // Sweep FSM with registered outputs and the mismatch scoreboard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            x_out_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            first_q    <= '0;
            // NOTE: captured is a plain register vector, not a RAM, so it is reset like any flop.
            captured_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q    <= SETTLE;
                        idx_q      <= '0;
                        x_out_q    <= '0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        err_q      <= '0;
                        first_q    <= '0;
                        captured_q <= '0;
                    end
                end
                SETTLE: begin
                    if (ctl_if.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (cnt_expire) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (ctl_if.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        captured_q[idx_q] <= s_in_i;
                        if (mismatch) begin
                            err_q <= err_d;
                            // A zero count means this is the first mismatch of the sweep.
                            if (err_q == '0) first_q <= idx_q;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            state_q <= SETTLE;
                            idx_q   <= idx_q + 1'b1;
                            x_out_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    if (ctl_if.abort) pass_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x_out_o              = x_out_q;
    assign ctl_if.busy          = busy_q;
    assign ctl_if.done          = done_q;
    assign ctl_if.pass          = pass_q;
    assign ctl_if.err_count     = err_q;
    assign ctl_if.first_err_idx = first_q;
    assign ctl_if.captured      = captured_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench: four controller instances share start/abort/reset and
// each sweeps a behavioural gate defined by a truth-table variable.
module tb_gate_sweep_ctrl;

    localparam int SWEEP_LEN = 30;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;

    logic [3:0] tt2;   // gate seen by the three 2-input instances
    logic [7:0] tt3;   // gate seen by the 3-input instance

    logic [1:0] x0, x1, x2;
    logic [2:0] x3;
    logic       s0, s1, s2, s3;

    int n_checks = 0;
    int n_err    = 0;

    // Instance configuration used by the reference model.
    int n_of [4] = '{2, 2, 2, 3};
    int s_of [4] = '{1, 1, 3, 2};
    int e_of [4] = '{32'hE, 32'h8, 32'hE, 32'hE8};

    always #5 clk = ~clk;

    gate_sweep_ctrl_if #(.N_IN(2)) if0 ();
    gate_sweep_ctrl_if #(.N_IN(2)) if1 ();
    gate_sweep_ctrl_if #(.N_IN(2)) if2 ();
    gate_sweep_ctrl_if #(.N_IN(3)) if3 ();

    assign if0.start = start;  assign if0.abort = abort;
    assign if1.start = start;  assign if1.abort = abort;
    assign if2.start = start;  assign if2.abort = abort;
    assign if3.start = start;  assign if3.abort = abort;

    assign s0 = tt2[x0];
    assign s1 = tt2[x1];
    assign s2 = tt2[x2];
    assign s3 = tt3[x3];

    gate_sweep_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .ctl_if(if0), .x_out_o(x0), .s_in_i(s0)
    );
    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1), .EXPECT(4'b1000)) u1 (
        .clk(clk), .rst_n(rst_n), .ctl_if(if1), .x_out_o(x1), .s_in_i(s1)
    );
    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(3), .EXPECT(4'b1110)) u2 (
        .clk(clk), .rst_n(rst_n), .ctl_if(if2), .x_out_o(x2), .s_in_i(s2)
    );
    gate_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(2), .EXPECT(8'hE8)) u3 (
        .clk(clk), .rst_n(rst_n), .ctl_if(if3), .x_out_o(x3), .s_in_i(s3)
    );

    // Uniform view of all instances for loop-based checking.
    int   obs_x [4];
    int   obs_err [4];
    int   obs_first [4];
    int   obs_cap [4];
    logic obs_busy [4];
    logic obs_done [4];
    logic obs_pass [4];

    always_comb begin
        obs_x[0] = int'(x0);  obs_x[1] = int'(x1);  obs_x[2] = int'(x2);  obs_x[3] = int'(x3);
        obs_busy[0] = if0.busy;  obs_busy[1] = if1.busy;  obs_busy[2] = if2.busy;  obs_busy[3] = if3.busy;
        obs_done[0] = if0.done;  obs_done[1] = if1.done;  obs_done[2] = if2.done;  obs_done[3] = if3.done;
        obs_pass[0] = if0.pass;  obs_pass[1] = if1.pass;  obs_pass[2] = if2.pass;  obs_pass[3] = if3.pass;
        obs_err[0] = int'(if0.err_count);  obs_err[1] = int'(if1.err_count);
        obs_err[2] = int'(if2.err_count);  obs_err[3] = int'(if3.err_count);
        obs_first[0] = int'(if0.first_err_idx);  obs_first[1] = int'(if1.first_err_idx);
        obs_first[2] = int'(if2.first_err_idx);  obs_first[3] = int'(if3.first_err_idx);
        obs_cap[0] = int'(if0.captured);  obs_cap[1] = int'(if1.captured);
        obs_cap[2] = int'(if2.captured);  obs_cap[3] = int'(if3.captured);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tt_of(input int d);
        return (d < 3) ? int'(tt2) : int'(tt3);
    endfunction

    // Reference: results follow directly from truth table vs expectation.
    function automatic void model(input int d, input int tt,
                                  output int dcyc, output int err, output int first,
                                  output int pass, output int cap);
        int nv;
        int diff;
        nv    = 1 << n_of[d];
        cap   = tt & ((1 << nv) - 1);
        diff  = (cap ^ e_of[d]) & ((1 << nv) - 1);
        err   = 0;
        first = 0;
        for (int k = nv - 1; k >= 0; k--) begin
            if (((diff >> k) & 1) == 1) begin
                err++;
                first = k;
            end
        end
        pass = (err == 0) ? 1 : 0;
        dcyc = nv * (s_of[d] + 1) + 1;
    endfunction

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s u%0d x_out", tag, d), obs_x[d], 0);
            check($sformatf("%s u%0d busy", tag, d), int'(obs_busy[d]), 0);
            check($sformatf("%s u%0d done", tag, d), int'(obs_done[d]), 0);
            check($sformatf("%s u%0d pass", tag, d), int'(obs_pass[d]), 0);
            check($sformatf("%s u%0d err_count", tag, d), obs_err[d], 0);
            check($sformatf("%s u%0d first_err_idx", tag, d), obs_first[d], 0);
            check($sformatf("%s u%0d captured", tag, d), obs_cap[d], 0);
        end
    endtask

    // Full sweep from IDLE; start may be re-pulsed at cycles re_a/re_b (must be ignored).
    task automatic run_sweep(input string tag, input int re_a, input int re_b);
        int dcnt [4];
        int dcyc [4];
        int xbad [4];
        int bbad [4];
        int m_dcyc, m_err, m_first, m_pass, m_cap;
        for (int d = 0; d < 4; d++) begin
            dcnt[d] = 0; dcyc[d] = 0; xbad[d] = 0; bbad[d] = 0;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= SWEEP_LEN; c++) begin
            for (int d = 0; d < 4; d++) begin
                int dc;
                int ex;
                model(d, tt_of(d), dc, m_err, m_first, m_pass, m_cap);
                if (obs_done[d]) begin
                    if (dcnt[d] == 0) dcyc[d] = c;
                    dcnt[d]++;
                end
                ex = (c < dc) ? (c - 1) / (s_of[d] + 1) : (1 << n_of[d]) - 1;
                if (obs_x[d] != ex) xbad[d]++;
                if (int'(obs_busy[d]) != ((c < dc) ? 1 : 0)) bbad[d]++;
            end
            start = (c == re_a) || (c == re_b);
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int d = 0; d < 4; d++) begin
            model(d, tt_of(d), m_dcyc, m_err, m_first, m_pass, m_cap);
            check($sformatf("%s u%0d done_pulses", tag, d), dcnt[d], 1);
            check($sformatf("%s u%0d done_cycle", tag, d), dcyc[d], m_dcyc);
            check($sformatf("%s u%0d x_out_bad_cycles", tag, d), xbad[d], 0);
            check($sformatf("%s u%0d busy_bad_cycles", tag, d), bbad[d], 0);
            check($sformatf("%s u%0d pass", tag, d), int'(obs_pass[d]), m_pass);
            check($sformatf("%s u%0d err_count", tag, d), obs_err[d], m_err);
            check($sformatf("%s u%0d first_err_idx", tag, d), obs_first[d], m_first);
            check($sformatf("%s u%0d captured", tag, d), obs_cap[d], m_cap);
        end
    endtask

    typedef struct {
        logic [3:0] tt;
        int         re_a;
        int         re_b;
        int         p0, e0, f0;   // hand-derived results for the OR-expecting instance
        int         p1, e1, f1;   // hand-derived results for the AND-expecting instance
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{4'b1110, 3, 9, 1, 0, 0, 0, 2, 1};   // OR gate, start re-pulsed while busy/DONE
        vecs[1] = '{4'b1000, 0, 0, 0, 2, 1, 1, 0, 0};   // AND gate
        vecs[2] = '{4'b0111, 0, 0, 0, 2, 0, 0, 4, 0};   // NAND gate, all four vectors wrong for AND
        vecs[3] = '{4'b0110, 0, 0, 0, 1, 3, 0, 3, 1};   // XOR gate, only last vector wrong for OR
        vecs[4] = '{4'b1111, 0, 0, 0, 1, 0, 0, 3, 0};   // stuck-at-1 output

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tt2   = 4'b1110;
        tt3   = 8'hE8;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven sweeps.
        for (int i = 0; i < 5; i++) begin
            tt2 = vecs[i].tt;
            tt3 = 8'($urandom);
            run_sweep($sformatf("vec%0d", i), vecs[i].re_a, vecs[i].re_b);
            check($sformatf("vec%0d u0 pass_tbl", i), int'(obs_pass[0]), vecs[i].p0);
            check($sformatf("vec%0d u0 err_tbl", i), obs_err[0], vecs[i].e0);
            check($sformatf("vec%0d u0 first_tbl", i), obs_first[0], vecs[i].f0);
            check($sformatf("vec%0d u1 pass_tbl", i), int'(obs_pass[1]), vecs[i].p1);
            check($sformatf("vec%0d u1 err_tbl", i), obs_err[1], vecs[i].e1);
            check($sformatf("vec%0d u1 first_tbl", i), obs_first[1], vecs[i].f1);
        end

        // Random gates against the reference model.
        for (int i = 0; i < 6; i++) begin
            tt2 = 4'($urandom);
            tt3 = 8'($urandom);
            run_sweep($sformatf("rnd%0d", i), 0, 0);
        end

        // Abort during cycle 4: IDLE by cycle 5, no done pulse anywhere.
        begin
            int dn [4];
            for (int d = 0; d < 4; d++) dn[d] = 0;
            tt2 = 4'b1110;
            tt3 = 8'hE8;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 1; c <= SWEEP_LEN; c++) begin
                for (int d = 0; d < 4; d++) if (obs_done[d]) dn[d]++;
                if (c == 4) check("abort u0 busy_before", int'(obs_busy[0]), 1);
                if (c == 5) begin
                    for (int d = 0; d < 4; d++) begin
                        check($sformatf("abort u%0d busy", d), int'(obs_busy[d]), 0);
                        check($sformatf("abort u%0d pass", d), int'(obs_pass[d]), 0);
                    end
                end
                abort = (c == 4);
                @(posedge clk); #1;
            end
            abort = 1'b0;
            for (int d = 0; d < 4; d++) check($sformatf("abort u%0d done_pulses", d), dn[d], 0);
        end
        run_sweep("after_abort", 0, 0);

        // Abort and start together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < 4; d++)
                check($sformatf("start_abort u%0d busy_%0d", d, k), int'(obs_busy[d]), 0);
            @(posedge clk); #1;
        end

        // Reset asserted during cycle 5 of a sweep.
        tt2 = 4'b1000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        tt2 = 4'b1110;
        run_sweep("after_reset", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
